// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU SELECT/SHIFT codes, default latencies and the
//                controller state enum for alu_arb_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   // ALU SELECT codes
   localparam logic [2:0] SEL_FWD = 3'b000;
   localparam logic [2:0] SEL_ADD = 3'b001;
   localparam logic [2:0] SEL_AND = 3'b010;
   localparam logic [2:0] SEL_OR  = 3'b011;
   localparam logic [2:0] SEL_CMP = 3'b100;
   localparam logic [2:0] SEL_ROR = 3'b101;
   localparam logic [2:0] SEL_SHF = 3'b110;
   localparam logic [2:0] SEL_NOP = 3'b111;

   // ALU SHIFT codes (00 carries no shift and is illegal with SHF)
   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_SLL  = 2'b01;
   localparam logic [1:0] SH_SRL  = 2'b10;
   localparam logic [1:0] SH_SRA  = 2'b11;

   // Default wait-cycle counts
   localparam int LAT_ADD_DEFAULT = 2;
   localparam int LAT_DEF_DEFAULT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // A shift op without a shift code has no meaning for the ALU
   function automatic logic is_illegal(input logic [2:0] sel, input logic [1:0] sh);
      return (sel == SEL_SHF) && (sh == SH_NONE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. A lone requester always wins;
//                on a tie the requester that did not win last time wins.
//                The priority pointer moves only when a grant is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   // prio = 1 means requester 1 wins a tie
   logic prio;

   // Grant selection from current requests and priority pointer
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // After an accepted grant, hand tie priority to the other requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (accept) begin
         prio <= grant[0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_ctrl
//  Description : Shares one 8-bit ALU between the main datapath (ID 0) and
//                the branch/compare unit (ID 1). Round-robin accept, operand
//                latch, fixed per-op wait, result capture and a valid/ready
//                response tagged with the requester ID.
//                Optional macro ALU_ARB_STATS_EN adds per-requester 16-bit
//                accept counters STAT_CNT0 / STAT_CNT1.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arb_ctrl
   import alu_pkg::*;
#(
   parameter int LAT_ADD = LAT_ADD_DEFAULT,
   parameter int LAT_DEF = LAT_DEF_DEFAULT
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] REQ_VALID,
   output logic [1:0] REQ_READY,
   input  logic [5:0] REQ_OP,
   input  logic [3:0] REQ_SHIFT,
   input  logic [15:0] REQ_A,
   input  logic [15:0] REQ_B,
   output logic [7:0] ALU_DATA1,
   output logic [7:0] ALU_DATA2,
   output logic [2:0] ALU_SELECT,
   output logic [1:0] ALU_SHIFT,
   input  logic [7:0] ALU_RESULT,
   input  logic       ALU_ZERO,
   output logic       RSP_VALID,
   input  logic       RSP_READY,
   output logic       RSP_ID,
   output logic [7:0] RSP_RESULT,
   output logic       RSP_ZERO,
   output logic       RSP_ERR
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0] STAT_CNT0,
   output logic [15:0] STAT_CNT1
`endif
);

   state_t      state, state_nxt;
   logic [1:0]  grant;
   logic        accept;
   logic        gid;
   logic [2:0]  op_in;
   logic [1:0]  sh_in;
   logic [7:0]  a_in, b_in;
   logic        illegal_in;
   logic [7:0]  lat_in;

   logic [7:0]  cnt;
   logic [2:0]  op_q;
   logic        id_q;
   logic        err_q;

   rr_arb2 u_arb (
      .clk    (CLK),
      .rst_n  (RESET),
      .req    (REQ_VALID),
      .accept (accept),
      .grant  (grant)
   );

   assign REQ_READY = (state == IDLE) ? grant : 2'b00;
   assign accept    = |(REQ_VALID & REQ_READY);
   assign gid       = grant[1];

   // Mux the granted requester's fields and derive its wait count
   always_comb begin
      op_in      = gid ? REQ_OP[5:3]    : REQ_OP[2:0];
      sh_in      = gid ? REQ_SHIFT[3:2] : REQ_SHIFT[1:0];
      a_in       = gid ? REQ_A[15:8]    : REQ_A[7:0];
      b_in       = gid ? REQ_B[15:8]    : REQ_B[7:0];
      illegal_in = is_illegal(op_in, sh_in);
      if (!illegal_in && (op_in == SEL_ADD || op_in == SEL_CMP)) begin
         lat_in = 8'(LAT_ADD);
      end else begin
         lat_in = 8'(LAT_DEF);
      end
   end

   // State register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)        state_nxt = EXEC;
         EXEC:    if (cnt == 8'd1)   state_nxt = RESP;
         RESP:    if (RSP_READY)     state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Operand latch, ALU drive, wait counter and response capture
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt        <= 8'd0;
         op_q       <= SEL_FWD;
         id_q       <= 1'b0;
         err_q      <= 1'b0;
         ALU_DATA1  <= 8'd0;
         ALU_DATA2  <= 8'd0;
         ALU_SELECT <= SEL_FWD;
         ALU_SHIFT  <= SH_NONE;
         RSP_VALID  <= 1'b0;
         RSP_ID     <= 1'b0;
         RSP_RESULT <= 8'd0;
         RSP_ZERO   <= 1'b0;
         RSP_ERR    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt        <= lat_in;
                  op_q       <= op_in;
                  id_q       <= gid;
                  err_q      <= illegal_in;
                  ALU_DATA1  <= a_in;
                  ALU_DATA2  <= b_in;
                  // Illegal ops park the ALU on NOP instead of driving SHF
                  ALU_SELECT <= illegal_in ? SEL_NOP : op_in;
                  ALU_SHIFT  <= sh_in;
               end
            end
            EXEC: begin
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) begin
                  RSP_VALID <= 1'b1;
                  RSP_ID    <= id_q;
                  RSP_ERR   <= err_q;
                  if (err_q) begin
                     RSP_RESULT <= 8'd0;
                     RSP_ZERO   <= 1'b0;
                  end else if (op_q == SEL_CMP) begin
                     // The ALU leaves RESULT undriven on compare; only ZERO is valid
                     RSP_RESULT <= 8'd0;
                     RSP_ZERO   <= ALU_ZERO;
                  end else begin
                     // ALU ZERO is stale outside compare, so derive it here
                     RSP_RESULT <= ALU_RESULT;
                     RSP_ZERO   <= (ALU_RESULT == 8'd0);
                  end
               end
            end
            RESP: begin
               if (RSP_READY) begin
                  RSP_VALID <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   // Per-requester accept counters, wrapping naturally at 16 bits
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         STAT_CNT0 <= 16'd0;
         STAT_CNT1 <= 16'd0;
      end else if (accept) begin
         if (gid) begin
            STAT_CNT1 <= STAT_CNT1 + 16'd1;
         end else begin
            STAT_CNT0 <= STAT_CNT0 + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arb_ctrl
//  Description : Directed self-checking bench for alu_arb_ctrl with a small
//                behavioural ALU attached to the ALU_* ports.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arb_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  REQ_VALID;
   logic [1:0]  REQ_READY;
   logic [5:0]  REQ_OP;
   logic [3:0]  REQ_SHIFT;
   logic [15:0] REQ_A;
   logic [15:0] REQ_B;
   logic [7:0]  ALU_DATA1, ALU_DATA2;
   logic [2:0]  ALU_SELECT;
   logic [1:0]  ALU_SHIFT;
   logic [7:0]  ALU_RESULT;
   logic        ALU_ZERO;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic        RSP_ID;
   logic [7:0]  RSP_RESULT;
   logic        RSP_ZERO;
   logic        RSP_ERR;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] STAT_CNT0, STAT_CNT1;
`endif

   int checks   = 0;
   int failures = 0;

   alu_arb_ctrl dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .REQ_VALID  (REQ_VALID),
      .REQ_READY  (REQ_READY),
      .REQ_OP     (REQ_OP),
      .REQ_SHIFT  (REQ_SHIFT),
      .REQ_A      (REQ_A),
      .REQ_B      (REQ_B),
      .ALU_DATA1  (ALU_DATA1),
      .ALU_DATA2  (ALU_DATA2),
      .ALU_SELECT (ALU_SELECT),
      .ALU_SHIFT  (ALU_SHIFT),
      .ALU_RESULT (ALU_RESULT),
      .ALU_ZERO   (ALU_ZERO),
      .RSP_VALID  (RSP_VALID),
      .RSP_READY  (RSP_READY),
      .RSP_ID     (RSP_ID),
      .RSP_RESULT (RSP_RESULT),
      .RSP_ZERO   (RSP_ZERO),
      .RSP_ERR    (RSP_ERR)
`ifdef ALU_ARB_STATS_EN
      ,
      .STAT_CNT0  (STAT_CNT0),
      .STAT_CNT1  (STAT_CNT1)
`endif
   );

   always #5 CLK = ~CLK;

   // Behavioural ALU: RESULT is junk on CMP/NOP, ZERO is stale (1) off CMP
   logic [7:0] sum;
   always_comb begin
      sum        = ALU_DATA1 + ALU_DATA2;
      ALU_RESULT = ALU_DATA1;
      ALU_ZERO   = 1'b1;
      case (ALU_SELECT)
         3'b000: ALU_RESULT = ALU_DATA1;
         3'b001: ALU_RESULT = sum;
         3'b010: ALU_RESULT = ALU_DATA1 & ALU_DATA2;
         3'b011: ALU_RESULT = ALU_DATA1 | ALU_DATA2;
         3'b100: begin ALU_RESULT = 8'hAA; ALU_ZERO = (sum == 8'h00); end
         3'b110: begin
            case (ALU_SHIFT)
               2'b01:   ALU_RESULT = ALU_DATA1 << ALU_DATA2[2:0];
               2'b10:   ALU_RESULT = ALU_DATA1 >> ALU_DATA2[2:0];
               2'b11:   ALU_RESULT = 8'($signed(ALU_DATA1) >>> ALU_DATA2[2:0]);
               default: ALU_RESULT = 8'h5A;
            endcase
         end
         3'b111: ALU_RESULT = 8'h5A;
         default: ALU_RESULT = ALU_DATA1;
      endcase
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Bounded wait until some REQ_READY bit is high (no comparison here)
   task automatic wait_ready(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (REQ_READY != 2'b00) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Bounded wait until RSP_VALID is high (no comparison here)
   task automatic wait_rsp(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (RSP_VALID === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic set_req(input int id, input logic [2:0] op, input logic [1:0] sh,
                          input logic [7:0] a, input logic [7:0] b);
      if (id == 0) begin
         REQ_OP[2:0] = op; REQ_SHIFT[1:0] = sh; REQ_A[7:0] = a; REQ_B[7:0] = b;
      end else begin
         REQ_OP[5:3] = op; REQ_SHIFT[3:2] = sh; REQ_A[15:8] = a; REQ_B[15:8] = b;
      end
   endtask

   task automatic do_reset;
      RESET = 1'b0;
      repeat (2) tick();
      RESET = 1'b1;
      tick();
   endtask

   // Drive one transaction to completion with RSP_READY high (stimulus only)
   task automatic run_op(input int id, input logic [2:0] op, input logic [1:0] sh,
                         input logic [7:0] a, input logic [7:0] b, output logic ok);
      logic ok1, ok2;
      set_req(id, op, sh, a, b);
      REQ_VALID = (id == 0) ? 2'b01 : 2'b10;
      RSP_READY = 1'b1;
      wait_ready(ok1);
      tick();
      REQ_VALID = 2'b00;
      wait_rsp(ok2);
      tick();
      ok = ok1 & ok2;
   endtask

   task automatic test_reset;
      RESET = 1'b0;
      REQ_VALID = 2'b00; REQ_OP = '0; REQ_SHIFT = '0; REQ_A = '0; REQ_B = '0;
      RSP_READY = 1'b1;
      repeat (2) tick();
      checks++; if (REQ_READY !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b want 00", REQ_READY); end
      checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); end
      checks++; if ({ALU_SELECT, ALU_SHIFT, ALU_DATA1, ALU_DATA2} !== 21'd0) begin failures++; $display("FAIL reset_alu: got sel=%b sh=%b d1=%h d2=%h want zeros", ALU_SELECT, ALU_SHIFT, ALU_DATA1, ALU_DATA2); end
      checks++; if ({RSP_ID, RSP_RESULT, RSP_ZERO, RSP_ERR} !== 11'd0) begin failures++; $display("FAIL reset_rsp: got id=%b res=%h z=%b e=%b want zeros", RSP_ID, RSP_RESULT, RSP_ZERO, RSP_ERR); end
      RESET = 1'b1;
      tick();
   endtask

   task automatic test_single;
      set_req(0, 3'b001, 2'b00, 8'h05, 8'h03);
      REQ_VALID = 2'b01;
      RSP_READY = 1'b1;
      #1;
      checks++; if (REQ_READY !== 2'b01) begin failures++; $display("FAIL single_ready: got %b want 01", REQ_READY); end
      tick();  // accept edge
      REQ_VALID = 2'b00;
      set_req(0, 3'b010, 2'b00, 8'hEE, 8'hEE);  // must not affect the op
      checks++; if (ALU_SELECT !== 3'b001 || ALU_DATA1 !== 8'h05 || ALU_DATA2 !== 8'h03) begin failures++; $display("FAIL single_alu_c0: got sel=%b d1=%h d2=%h want 001/05/03", ALU_SELECT, ALU_DATA1, ALU_DATA2); end
      checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL single_early_c0: got %b want 0", RSP_VALID); end
      tick();
      checks++; if (ALU_SELECT !== 3'b001 || RSP_VALID !== 1'b0) begin failures++; $display("FAIL single_c1: got sel=%b valid=%b want 001/0", ALU_SELECT, RSP_VALID); end
      tick();
      checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 1'b0 || RSP_RESULT !== 8'h08 || RSP_ZERO !== 1'b0 || RSP_ERR !== 1'b0) begin failures++; $display("FAIL single_rsp: got v=%b id=%b res=%h z=%b e=%b want 1/0/08/0/0", RSP_VALID, RSP_ID, RSP_RESULT, RSP_ZERO, RSP_ERR); end
      tick();
      checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL single_rsp_drop: got %b want 0", RSP_VALID); end
   endtask

   task automatic test_contention;
      logic ok;
      logic [1:0] exp_g;
      logic [7:0] exp_r;
      RESET = 1'b0;
      set_req(0, 3'b010, 2'b00, 8'hFF, 8'h0F);
      set_req(1, 3'b011, 2'b00, 8'h10, 8'h01);
      REQ_VALID = 2'b11;
      RSP_READY = 1'b1;
      repeat (2) tick();
      RESET = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         exp_r = (t % 2 == 0) ? 8'h0F : 8'h11;
         wait_ready(ok);
         checks++; if (!ok || REQ_READY !== exp_g) begin failures++; $display("FAIL contention_grant%0d: got %b want %b", t, REQ_READY, exp_g); end
         tick();
         wait_rsp(ok);
         checks++; if (!ok || RSP_ID !== exp_g[1] || RSP_RESULT !== exp_r) begin failures++; $display("FAIL contention_rsp%0d: got v=%b id=%b res=%h want id=%b res=%h", t, RSP_VALID, RSP_ID, RSP_RESULT, exp_g[1], exp_r); end
         tick();
      end
      REQ_VALID = 2'b00;
      tick();
   endtask

   task automatic test_compare_backpressure;
      logic ok;
      set_req(1, 3'b100, 2'b00, 8'h07, 8'hF9);
      REQ_VALID = 2'b10;
      RSP_READY = 1'b0;
      wait_ready(ok);
      tick();
      set_req(0, 3'b000, 2'b00, 8'h33, 8'h00);
      REQ_VALID = 2'b01;  // requester 0 must wait
      #1;
      checks++; if (!ok || ALU_SELECT !== 3'b100 || REQ_READY !== 2'b00) begin failures++; $display("FAIL cmp_exec: got sel=%b ready=%b want 100/00", ALU_SELECT, REQ_READY); end
      wait_rsp(ok);
      for (int c = 0; c < 3; c++) begin
         checks++; if (!ok || RSP_VALID !== 1'b1 || RSP_ID !== 1'b1 || RSP_RESULT !== 8'h00 || RSP_ZERO !== 1'b1 || REQ_READY !== 2'b00) begin failures++; $display("FAIL cmp_hold%0d: got v=%b id=%b res=%h z=%b ready=%b want 1/1/00/1/00", c, RSP_VALID, RSP_ID, RSP_RESULT, RSP_ZERO, REQ_READY); end
         tick();
      end
      RSP_READY = 1'b1;
      tick();
      checks++; if (RSP_VALID !== 1'b0 || REQ_READY !== 2'b01) begin failures++; $display("FAIL cmp_release: got v=%b ready=%b want 0/01", RSP_VALID, REQ_READY); end
      REQ_VALID = 2'b00;
      tick();
   endtask

   task automatic test_illegal;
      logic ok;
      set_req(0, 3'b110, 2'b00, 8'h03, 8'h02);
      REQ_VALID = 2'b01;
      RSP_READY = 1'b1;
      wait_ready(ok);
      tick();
      REQ_VALID = 2'b00;
      checks++; if (!ok || ALU_SELECT !== 3'b111) begin failures++; $display("FAIL illegal_sel: got %b want 111", ALU_SELECT); end
      tick();
      checks++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RESULT !== 8'h00) begin failures++; $display("FAIL illegal_rsp: got v=%b e=%b res=%h want 1/1/00", RSP_VALID, RSP_ERR, RSP_RESULT); end
      tick();
      set_req(0, 3'b110, 2'b01, 8'h03, 8'h02);
      REQ_VALID = 2'b01;
      wait_ready(ok);
      tick();
      REQ_VALID = 2'b00;
      checks++; if (!ok || ALU_SELECT !== 3'b110 || ALU_SHIFT !== 2'b01) begin failures++; $display("FAIL shf_sel: got sel=%b sh=%b want 110/01", ALU_SELECT, ALU_SHIFT); end
      tick();
      checks++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RESULT !== 8'h0C) begin failures++; $display("FAIL shf_rsp: got v=%b e=%b res=%h want 1/0/0C", RSP_VALID, RSP_ERR, RSP_RESULT); end
      tick();
   endtask

   task automatic test_reset_mid;
      logic ok;
      set_req(0, 3'b001, 2'b00, 8'h10, 8'h20);
      REQ_VALID = 2'b01;
      RSP_READY = 1'b1;
      wait_ready(ok);
      tick();
      REQ_VALID = 2'b00;
      RESET = 1'b0;
      #1;
      checks++; if (ALU_SELECT !== 3'b000 || ALU_DATA1 !== 8'h00 || REQ_READY !== 2'b00 || RSP_VALID !== 1'b0) begin failures++; $display("FAIL midreset_outputs: got sel=%b d1=%h ready=%b v=%b want zeros", ALU_SELECT, ALU_DATA1, REQ_READY, RSP_VALID); end
      tick();
      RESET = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL midreset_norsp%0d: got %b want 0", c, RSP_VALID); end
      end
      set_req(1, 3'b001, 2'b00, 8'h01, 8'h02);
      REQ_VALID = 2'b10;
      wait_ready(ok);
      tick();
      REQ_VALID = 2'b00;
      wait_rsp(ok);
      checks++; if (!ok || RSP_ID !== 1'b1 || RSP_RESULT !== 8'h03 || RSP_ERR !== 1'b0) begin failures++; $display("FAIL midreset_next: got v=%b id=%b res=%h want 1/1/03", RSP_VALID, RSP_ID, RSP_RESULT); end
      tick();
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic test_stats;
      logic ok;
      logic all_ok;
      do_reset();
      checks++; if (STAT_CNT0 !== 16'd0 || STAT_CNT1 !== 16'd0) begin failures++; $display("FAIL stats_reset: got %h/%h want 0000/0000", STAT_CNT0, STAT_CNT1); end
      all_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin run_op(0, 3'b000, 2'b00, 8'(i), 8'h00, ok); all_ok &= ok; end
      for (int i = 0; i < 2; i++) begin run_op(1, 3'b000, 2'b00, 8'(i), 8'h00, ok); all_ok &= ok; end
      checks++; if (!all_ok || STAT_CNT0 !== 16'd3 || STAT_CNT1 !== 16'd2) begin failures++; $display("FAIL stats_count: got %h/%h want 0003/0002", STAT_CNT0, STAT_CNT1); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_compare_backpressure();
      test_illegal();
      test_reset_mid();
`ifdef ALU_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
